// File: rtl/weight_update_writer.sv
// Output-layer weight write-back: read-modify-write of N_OUT x N_HID weights in RAM.
// Optional macro WEIGHT_SAT_EN: saturate updated weights to [-512, 511] instead of wrapping.
module weight_update_writer #(
   parameter int unsigned N_OUT     = 3,
   parameter int unsigned N_HID     = 5,
   parameter logic [6:0]  BASE0     = 7'd50,
   parameter logic [6:0]  BASE1     = 7'd55,
   parameter logic [6:0]  BASE2     = 7'd60,
   parameter int unsigned FRAC_BITS = 8,
   parameter int unsigned LR_SHIFT  = 2
) (
   input  logic              Clock,
   input  logic              Rst,
   input  logic              Start,
   input  logic [9:0]        delta [0:N_OUT-1],
   input  logic [N_OUT-1:0]  sign,
   input  logic [9:0]        out_cal [0:N_HID-1],
   output logic [6:0]        ram_addr,
   output logic              ram_we,
   output logic signed [9:0] ram_wdata,
   input  logic signed [9:0] ram_rdata,
   output logic              Busy,
   output logic              Done
);

   localparam int unsigned K_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int unsigned J_W   = (N_HID > 1) ? $clog2(N_HID) : 1;
   localparam int unsigned SHIFT = FRAC_BITS + LR_SHIFT;
   localparam logic [K_W-1:0] K_LAST = K_W'(N_OUT - 1);
   localparam logic [J_W-1:0] J_LAST = J_W'(N_HID - 1);

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

   state_t state, state_nx;

   logic [9:0]       d_q  [0:N_OUT-1];
   logic [9:0]       oc_q [0:N_HID-1];
   logic [N_OUT-1:0] s_q;
   logic [K_W-1:0]   k;
   logic [J_W-1:0]   j;

   logic       k_last, j_last;
   logic [6:0] base_k;
   logic [6:0] addr_cur;
   logic [19:0] prod;
   logic [9:0] w_new;

   assign k_last = (k == K_LAST);
   assign j_last = (j == J_LAST);

   always_comb begin
      if (k == K_W'(0))
         base_k = BASE0;
      else if (k == K_W'(1))
         base_k = BASE1;
      else
         base_k = BASE2;
   end

   assign addr_cur = base_k + 7'(j);
   assign prod     = d_q[k] * oc_q[j];

`ifdef WEIGHT_SAT_EN
   logic signed [11:0] w_ext, inc_ext, sum;

   always_comb begin
      w_ext   = {{2{ram_rdata[9]}}, ram_rdata};
      inc_ext = 12'(prod >> SHIFT);
      sum     = s_q[k] ? (w_ext - inc_ext) : (w_ext + inc_ext);
      if (sum > 12'sd511)
         w_new = 10'h1FF;
      else if (sum < -12'sd512)
         w_new = 10'h200;
      else
         w_new = sum[9:0];
   end
`else
   logic [9:0] inc_lo;

   // Low 10 bits of the 12-bit sum equal the 10-bit modular sum, so only 10 bits are kept.
   always_comb begin
      inc_lo = 10'(prod >> SHIFT);
      w_new  = s_q[k] ? (ram_rdata - inc_lo) : (ram_rdata + inc_lo);
   end
`endif

   always_ff @(posedge Clock) begin
      if (!Rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (Start) state_nx = READ;
         READ:    state_nx = WRITE;
         WRITE:   state_nx = (j_last && k_last) ? DONE : READ;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operands are frozen at Start so the pass sees one consistent snapshot.
   always_ff @(posedge Clock) begin
      if (!Rst) begin
         d_q  <= '{default: '0};
         oc_q <= '{default: '0};
         s_q  <= '0;
         k    <= '0;
         j    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (Start) begin
                  d_q  <= delta;
                  oc_q <= out_cal;
                  s_q  <= sign;
                  k    <= '0;
                  j    <= '0;
               end
            end
            WRITE: begin
               if (!j_last) begin
                  j <= j + 1'b1;
               end else if (!k_last) begin
                  k <= k + 1'b1;
                  j <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Write enable is gated by Rst so a reset edge landing on WRITE never commits.
   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      Busy      = 1'b0;
      Done      = 1'b0;
      unique case (state)
         READ: begin
            ram_addr = addr_cur;
            Busy     = 1'b1;
         end
         WRITE: begin
            ram_addr  = addr_cur;
            ram_we    = Rst;
            ram_wdata = w_new;
            Busy      = 1'b1;
         end
         DONE:    Done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_weight_update_writer.sv
// Bench for weight_update_writer: RAM model plus pass-level reference model, checked every cycle.
module tb_weight_update_writer;

   logic              Clock = 1'b0;
   logic              Rst   = 1'b0;
   logic              Start = 1'b1;
   logic [9:0]        delta [0:2];
   logic [2:0]        sign;
   logic [9:0]        out_cal [0:4];
   logic [6:0]        ram_addr;
   logic              ram_we;
   logic signed [9:0] ram_wdata;
   logic signed [9:0] ram_rdata;
   logic              Busy;
   logic              Done;

   logic signed [9:0] mem     [0:127];
   logic signed [9:0] ref_mem [0:127];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   bit m_active = 1'b0;
   bit m_fresh  = 1'b1;
   int m_t      = 0;
   int m_d [3];
   int m_o [5];
   bit m_s [3];
   int base_tab [3] = '{50, 55, 60};

   int wr_count     = 0;
   int first_wr_cyc = -1;
   int first_wr_dat = 0;
   int done_q [$];
   int n_c, a_c, exp_we, exp_busy, exp_done;

`ifdef WEIGHT_SAT_EN
   localparam int SAT_POS = 511;
   localparam int SAT_NEG = -512;
`else
   localparam int SAT_POS = -492;
   localparam int SAT_NEG = 492;
`endif

   weight_update_writer dut (
      .Clock     (Clock),
      .Rst       (Rst),
      .Start     (Start),
      .delta     (delta),
      .sign      (sign),
      .out_cal   (out_cal),
      .ram_addr  (ram_addr),
      .ram_we    (ram_we),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .Busy      (Busy),
      .Done      (Done)
   );

   always #5 Clock = ~Clock;

   function automatic int upd(int w, int d, int o, bit s);
      int inc, r;
      inc = (d * o) / 1024;
      r   = s ? (w - inc) : (w + inc);
`ifdef WEIGHT_SAT_EN
      if (r > 511) r = 511;
      if (r < -512) r = -512;
`else
      r = ((r % 1024) + 1536) % 1024 - 512;
`endif
      return r;
   endfunction

   task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
      end
   endtask

   // RAM with one-cycle read latency, plus the reference model advancing on the same edge
   always @(posedge Clock) begin
      ram_rdata <= mem[ram_addr];
      if (ram_we) begin
         if (wr_count == 0) begin
            first_wr_cyc = cyc;
            first_wr_dat = ram_wdata;
         end
         wr_count++;
         mem[ram_addr] = ram_wdata;
      end
      if (!Rst) begin
         m_active = 1'b0;
         m_fresh  = 1'b1;
      end else if (!m_active) begin
         if (Start) begin
            m_active = 1'b1;
            m_fresh  = 1'b0;
            m_t      = 1;
            for (int i = 0; i < 3; i++) begin
               m_d[i] = delta[i];
               m_s[i] = sign[i];
            end
            for (int i = 0; i < 5; i++) m_o[i] = out_cal[i];
         end
      end else begin
         if (m_t % 2 == 0) begin
            n_c = (m_t - 1) / 2;
            a_c = base_tab[n_c / 5] + n_c % 5;
            ref_mem[a_c] = 10'(upd(ref_mem[a_c], m_d[n_c / 5], m_o[n_c % 5], m_s[n_c / 5]));
         end
         if (m_t == 31) m_active = 1'b0;
         else m_t++;
      end
      cyc++;
   end

   always @(negedge Clock) begin
      if (cyc > 0) begin
         exp_busy = 0;
         exp_done = 0;
         exp_we   = 0;
         if (m_active && m_t <= 30) begin
            n_c = (m_t - 1) / 2;
            a_c = base_tab[n_c / 5] + n_c % 5;
            exp_busy = 1;
            check("ram_addr", ram_addr, a_c);
            if (m_t % 2 == 0) begin
               exp_we = Rst ? 1 : 0;
               check("ram_wdata", ram_wdata,
                     upd(ref_mem[a_c], m_d[n_c / 5], m_o[n_c % 5], m_s[n_c / 5]));
            end
         end else if (m_active) begin
            exp_done = 1;
         end else if (m_fresh) begin
            check("reset_addr", ram_addr, 0);
            check("reset_wdata", ram_wdata, 0);
         end
         check("Busy", Busy, exp_busy);
         check("Done", Done, exp_done);
         check("ram_we", ram_we, exp_we);
         if (Done === 1'b1) done_q.push_back(cyc);
      end
   end

   task automatic tick;
      @(posedge Clock);
      #1;
   endtask

   task automatic set_ram(input int a, input int v);
      mem[a]     = 10'(v);
      ref_mem[a] = 10'(v);
   endtask

   task automatic cmp_mem;
      for (int a = 0; a < 128; a++) check($sformatf("mem[%0d]", a), mem[a], ref_mem[a]);
   endtask

   task automatic randomize_inputs;
      for (int i = 0; i < 3; i++) delta[i] = 10'($urandom_range(0, 1023));
      for (int i = 0; i < 5; i++) out_cal[i] = 10'($urandom_range(0, 1023));
      sign = 3'($urandom_range(0, 7));
      for (int a = 50; a < 65; a++) set_ram(a, $urandom_range(0, 1023) - 512);
   endtask

   task automatic run_pass(input bit noise, output int e);
      done_q.delete();
      wr_count     = 0;
      first_wr_cyc = -1;
      Start = 1'b1;
      e     = cyc;
      tick;
      Start = 1'b0;
      for (int i = 0; i < 40 && done_q.size() == 0; i++) begin
         Start = (noise && i < 26) ? 1'($urandom_range(0, 1)) : 1'b0;
         tick;
      end
      Start = 1'b0;
      check("done_cycle", (done_q.size() > 0) ? done_q[0] - e : -1, 31);
      tick;
   endtask

   int e;
   int pre [0:127];

   initial begin
      for (int a = 0; a < 128; a++) set_ram(a, 0);
      for (int i = 0; i < 3; i++) delta[i] = '0;
      for (int i = 0; i < 5; i++) out_cal[i] = '0;
      sign = '0;

      // reset held with Start high
      repeat (3) tick;
      Start = 1'b0;
      Rst   = 1'b1;
      tick;
      check("reset_no_writes", wr_count, 0);

      // basic add
      set_ram(50, 100);
      delta[0] = 10'd256; out_cal[0] = 10'd128; sign = 3'b000;
      run_pass(1'b0, e);
      check("basic_add", mem[50], 132);
      check("first_write_cycle", first_wr_cyc - e, 2);
      check("first_write_data", first_wr_dat, 132);
      cmp_mem();

      // subtract
      set_ram(50, 100);
      set_ram(64, -10);
      delta[2] = 10'd256; out_cal[4] = 10'd256; sign = 3'b101;
      run_pass(1'b0, e);
      check("sub_50", mem[50], 68);
      check("sub_64", mem[64], -74);
      cmp_mem();

      // saturation / wrap, both directions
      set_ram(55, 500);
      delta[1] = 10'd256; out_cal[0] = 10'd128; sign = 3'b000;
      run_pass(1'b0, e);
      check("sat_pos", mem[55], SAT_POS);
      set_ram(55, -500);
      sign = 3'b010;
      run_pass(1'b0, e);
      check("sat_neg", mem[55], SAT_NEG);
      cmp_mem();

      // full pass with Start noise during the pass
      for (int a = 0; a < 128; a++) set_ram(a, 0);
      for (int i = 0; i < 3; i++) delta[i] = 10'd256;
      for (int i = 0; i < 5; i++) out_cal[i] = 10'd256;
      sign = 3'b000;
      run_pass(1'b1, e);
      check("full_write_count", wr_count, 15);
      for (int a = 50; a < 65; a++) check($sformatf("full_%0d", a), mem[a], 64);
      cmp_mem();

      // Start held high: back-to-back passes
      done_q.delete();
      Start = 1'b1;
      for (int i = 0; i < 80 && done_q.size() < 2; i++) tick;
      Start = 1'b0;
      check("held_start_gap", (done_q.size() == 2) ? done_q[1] - done_q[0] : -1, 32);
      tick;
      cmp_mem();

      // reset during the WRITE to address 54
      randomize_inputs();
      for (int a = 0; a < 128; a++) pre[a] = mem[a];
      Start = 1'b1;
      e     = cyc;
      tick;
      Start = 1'b0;
      repeat (9) tick;
      Rst = 1'b0;
      tick;
      Rst = 1'b1;
      repeat (3) tick;
      check("midreset_busy", Busy, 0);
      for (int a = 54; a < 65; a++) check($sformatf("untouched_%0d", a), mem[a], pre[a]);
      cmp_mem();

      // randomized passes
      for (int p = 0; p < 6; p++) begin
         randomize_inputs();
         run_pass(1'b1, e);
         cmp_mem();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout at cycle %0d", cyc);
      $fatal(1);
   end

endmodule
